// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port,
// and the IF/ID register outputs.
interface if_stage_if;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_pc4;
  logic [15:0] branch_imm16;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        redirect_pending;

  modport master (
    input  stall, branch_taken, branch_pc4, branch_imm16, imem_data,
    output imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, redirect_pending
  );

  modport slave (
    output stall, branch_taken, branch_pc4, branch_imm16, imem_data,
    input  imem_addr, pc, if_id_inst, if_id_pc4, if_id_valid, redirect_pending
  );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem address, IF/ID register, and
// a one-deep holding slot for branch redirects that arrive during a stall.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0020,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst,
  if_stage_if.master  bus
);

  typedef enum logic {RUN, PEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic [31:0] inst_q, inst_nxt;
  logic [31:0] pc4_q, pc4_nxt;
  logic        valid_q, valid_nxt;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign target   = bus.branch_pc4 + {{14{bus.branch_imm16[15]}}, bus.branch_imm16, 2'b00};
  assign pc_plus4 = pc_q + 32'd4;

  // Priority: live branch, stalled branch, pending redirect, sequential fetch.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc_q;
    pend_target_nxt = pend_target;
    inst_nxt        = inst_q;
    pc4_nxt         = pc4_q;
    valid_nxt       = valid_q;
    if (bus.branch_taken && !bus.stall) begin
      pc_nxt    = target;
      inst_nxt  = NOP_INST;
      pc4_nxt   = '0;
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else if (bus.branch_taken) begin
      pend_target_nxt = target;
      state_nxt       = PEND;
    end else if (!bus.stall && state == PEND) begin
      pc_nxt    = pend_target;
      inst_nxt  = NOP_INST;
      pc4_nxt   = '0;
      valid_nxt = 1'b0;
      state_nxt = RUN;
    end else if (!bus.stall) begin
      pc_nxt    = pc_plus4;
      inst_nxt  = bus.imem_data;
      pc4_nxt   = pc_plus4;
      valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      pc_q        <= RESET_PC;
      pend_target <= '0;
      inst_q      <= NOP_INST;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc_q        <= pc_nxt;
      pend_target <= pend_target_nxt;
      inst_q      <= inst_nxt;
      pc4_q       <= pc4_nxt;
      valid_q     <= valid_nxt;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.imem_addr        = pc_q;
  assign bus.if_id_inst       = inst_q;
  assign bus.if_id_pc4        = pc4_q;
  assign bus.if_id_valid      = valid_q;
  assign bus.redirect_pending = (state == PEND);

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, sequential fetch, redirects (live,
// stalled, overwritten), address wrap and asynchronous reset mid-redirect.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0040_0020), .NOP_INST(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Two programmed words; every other address returns its own complement.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h0040_0020) return 32'h2008_0005;
    if (a == 32'h0040_0024) return 32'h0000_0000;
    return ~a;
  endfunction

  assign bus.imem_data = mem_f(bus.imem_addr);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_pc4 = '0;
    bus.branch_imm16 = '0;
    #1;
    checks++; if (bus.pc !== 32'h0040_0020) begin errors++; $display("FAIL reset_pc got %h exp %h", bus.pc, 32'h0040_0020); end
    checks++; if (bus.imem_addr !== 32'h0040_0020) begin errors++; $display("FAIL reset_imem_addr got %h exp %h", bus.imem_addr, 32'h0040_0020); end
    checks++; if (bus.if_id_inst !== 32'h0) begin errors++; $display("FAIL reset_inst got %h exp %h", bus.if_id_inst, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp %h", bus.if_id_pc4, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.if_id_valid); end
    checks++; if (bus.redirect_pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b exp 0", bus.redirect_pending); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    step();
    checks++; if (bus.if_id_inst !== 32'h2008_0005) begin errors++; $display("FAIL seq_inst got %h exp %h", bus.if_id_inst, 32'h2008_0005); end
    checks++; if (bus.if_id_pc4 !== 32'h0040_0024) begin errors++; $display("FAIL seq_pc4 got %h exp %h", bus.if_id_pc4, 32'h0040_0024); end
    checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got %b exp 1", bus.if_id_valid); end
    checks++; if (bus.pc !== 32'h0040_0024) begin errors++; $display("FAIL seq_pc got %h exp %h", bus.pc, 32'h0040_0024); end
  endtask

  task automatic test_backward_branch();
    bus.branch_taken = 1'b1;
    bus.branch_pc4 = 32'h0040_0028;
    bus.branch_imm16 = 16'hFFFE;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.pc !== 32'h0040_0020) begin errors++; $display("FAIL bb_pc got %h exp %h", bus.pc, 32'h0040_0020); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL bb_valid got %b exp 0", bus.if_id_valid); end
    checks++; if (bus.if_id_inst !== 32'h0) begin errors++; $display("FAIL bb_inst got %h exp %h", bus.if_id_inst, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin errors++; $display("FAIL bb_pc4 got %h exp %h", bus.if_id_pc4, 32'h0); end
    step();
    checks++; if (bus.if_id_inst !== 32'h2008_0005) begin errors++; $display("FAIL bb_target_inst got %h exp %h", bus.if_id_inst, 32'h2008_0005); end
    checks++; if (bus.if_id_pc4 !== 32'h0040_0024) begin errors++; $display("FAIL bb_target_pc4 got %h exp %h", bus.if_id_pc4, 32'h0040_0024); end
    checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL bb_target_valid got %b exp 1", bus.if_id_valid); end
  endtask

  // Entered with pc=0x0040_0024 and IF/ID holding the word from 0x0040_0020.
  task automatic test_stalled_redirect();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_pc4 = 32'h0040_0010;
    bus.branch_imm16 = 16'h0003;
    step();
    bus.branch_taken = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      checks++; if (bus.redirect_pending !== 1'b1) begin errors++; $display("FAIL stall_pending[%0d] got %b exp 1", i, bus.redirect_pending); end
      checks++; if (bus.pc !== 32'h0040_0024) begin errors++; $display("FAIL stall_pc_hold[%0d] got %h exp %h", i, bus.pc, 32'h0040_0024); end
      checks++; if (bus.if_id_inst !== 32'h2008_0005) begin errors++; $display("FAIL stall_inst_hold[%0d] got %h exp %h", i, bus.if_id_inst, 32'h2008_0005); end
      if (i < 2) step();
    end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.pc !== 32'h0040_001C) begin errors++; $display("FAIL stall_apply_pc got %h exp %h", bus.pc, 32'h0040_001C); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL stall_apply_valid got %b exp 0", bus.if_id_valid); end
    checks++; if (bus.if_id_inst !== 32'h0) begin errors++; $display("FAIL stall_apply_inst got %h exp %h", bus.if_id_inst, 32'h0); end
    checks++; if (bus.redirect_pending !== 1'b0) begin errors++; $display("FAIL stall_apply_pending got %b exp 0", bus.redirect_pending); end
  endtask

  task automatic test_overwrite();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_pc4 = 32'h0040_0000;
    bus.branch_imm16 = 16'h0010;
    step();
    bus.branch_imm16 = 16'h0040;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.redirect_pending !== 1'b1) begin errors++; $display("FAIL ow_pending got %b exp 1", bus.redirect_pending); end
    bus.stall = 1'b0;
    step();
    checks++; if (bus.pc !== 32'h0040_0100) begin errors++; $display("FAIL ow_pc got %h exp %h", bus.pc, 32'h0040_0100); end
    checks++; if (bus.redirect_pending !== 1'b0) begin errors++; $display("FAIL ow_pending_clear got %b exp 0", bus.redirect_pending); end
  endtask

  task automatic test_live_wins();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_pc4 = 32'h0040_0000;
    bus.branch_imm16 = 16'h0010;
    step();
    checks++; if (bus.redirect_pending !== 1'b1) begin errors++; $display("FAIL lw_pending got %b exp 1", bus.redirect_pending); end
    bus.stall = 1'b0;
    bus.branch_pc4 = 32'h0040_0200;
    bus.branch_imm16 = 16'h0001;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.pc !== 32'h0040_0204) begin errors++; $display("FAIL lw_pc got %h exp %h", bus.pc, 32'h0040_0204); end
    checks++; if (bus.redirect_pending !== 1'b0) begin errors++; $display("FAIL lw_pending_clear got %b exp 0", bus.redirect_pending); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL lw_valid got %b exp 0", bus.if_id_valid); end
    step();
    checks++; if (bus.pc !== 32'h0040_0208) begin errors++; $display("FAIL lw_next_pc got %h exp %h", bus.pc, 32'h0040_0208); end
    checks++; if (bus.if_id_inst !== 32'hFFBF_FDFB) begin errors++; $display("FAIL lw_next_inst got %h exp %h", bus.if_id_inst, 32'hFFBF_FDFB); end
    checks++; if (bus.if_id_pc4 !== 32'h0040_0208) begin errors++; $display("FAIL lw_next_pc4 got %h exp %h", bus.if_id_pc4, 32'h0040_0208); end
  endtask

  task automatic test_wrap();
    bus.branch_taken = 1'b1;
    bus.branch_pc4 = 32'h0000_0004;
    bus.branch_imm16 = 16'h8000;
    step();
    checks++; if (bus.pc !== 32'hFFFE_0004) begin errors++; $display("FAIL wrap_branch_pc got %h exp %h", bus.pc, 32'hFFFE_0004); end
    bus.branch_pc4 = 32'h0000_0000;
    bus.branch_imm16 = 16'hFFFF;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup_pc got %h exp %h", bus.pc, 32'hFFFF_FFFC); end
    step();
    checks++; if (bus.pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_seq_pc got %h exp %h", bus.pc, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0000_0000) begin errors++; $display("FAIL wrap_seq_pc4 got %h exp %h", bus.if_id_pc4, 32'h0); end
    checks++; if (bus.if_id_inst !== 32'h0000_0003) begin errors++; $display("FAIL wrap_seq_inst got %h exp %h", bus.if_id_inst, 32'h3); end
    checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL wrap_seq_valid got %b exp 1", bus.if_id_valid); end
  endtask

  task automatic test_async_reset();
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_pc4 = 32'h0040_0000;
    bus.branch_imm16 = 16'h0020;
    step();
    bus.branch_taken = 1'b0;
    checks++; if (bus.redirect_pending !== 1'b1) begin errors++; $display("FAIL ar_pending_before got %b exp 1", bus.redirect_pending); end
    #3 rst = 1'b1;
    #1;
    checks++; if (bus.pc !== 32'h0040_0020) begin errors++; $display("FAIL ar_pc got %h exp %h", bus.pc, 32'h0040_0020); end
    checks++; if (bus.imem_addr !== 32'h0040_0020) begin errors++; $display("FAIL ar_imem_addr got %h exp %h", bus.imem_addr, 32'h0040_0020); end
    checks++; if (bus.if_id_inst !== 32'h0) begin errors++; $display("FAIL ar_inst got %h exp %h", bus.if_id_inst, 32'h0); end
    checks++; if (bus.if_id_pc4 !== 32'h0) begin errors++; $display("FAIL ar_pc4 got %h exp %h", bus.if_id_pc4, 32'h0); end
    checks++; if (bus.if_id_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %b exp 0", bus.if_id_valid); end
    checks++; if (bus.redirect_pending !== 1'b0) begin errors++; $display("FAIL ar_pending got %b exp 0", bus.redirect_pending); end
    #2;
    rst = 1'b0;
    bus.stall = 1'b0;
    step();
    checks++; if (bus.pc !== 32'h0040_0024) begin errors++; $display("FAIL ar_resume_pc got %h exp %h", bus.pc, 32'h0040_0024); end
    checks++; if (bus.if_id_inst !== 32'h2008_0005) begin errors++; $display("FAIL ar_resume_inst got %h exp %h", bus.if_id_inst, 32'h2008_0005); end
    checks++; if (bus.if_id_valid !== 1'b1) begin errors++; $display("FAIL ar_resume_valid got %b exp 1", bus.if_id_valid); end
    checks++; if (bus.redirect_pending !== 1'b0) begin errors++; $display("FAIL ar_resume_pending got %b exp 0", bus.redirect_pending); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backward_branch();
    test_stalled_redirect();
    test_overwrite();
    test_live_wins();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
